// File: rtl/vga_pkg.sv
// Shared constants for the VGA frame-buffer slice.
// Holds the default RAM geometry, the grant encoding the VRAM arbiter uses
// and the frame size, which the timing generator also uses.
package vga_pkg;

  localparam int AW_DEF = 15;  // 160x120 = 19200 words
  localparam int DW_DEF = 8;   // RRRGGGBB

  localparam int FRAME_W     = 160;
  localparam int FRAME_H     = 120;
  localparam int FRAME_WORDS = FRAME_W * FRAME_H;

  localparam int NUM_WR = 2;   // wr0 = drawing engine, wr1 = host loader

  // Grant encoding. Bit 1 set means a writer holds the slot, and bit 0 then
  // selects which one.
  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_DISP = 2'd1;
  localparam logic [1:0] GNT_WR0  = 2'd2;
  localparam logic [1:0] GNT_WR1  = 2'd3;

endpackage

// File: rtl/vram_starve_mon.sv
// Per-writer starvation monitor: counts consecutive stalled cycles and raises
// a sticky flag once the count reaches STARVE_LIMIT.
// Ports: clk, rst_n (async low), valid/ready of the watched writer,
//        clr (clears the flag, wins over a set), flag (sticky output).
module vram_starve_mon #(
  parameter int STARVE_LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid,
  input  logic ready,
  input  logic clr,
  output logic flag
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt, cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (!valid || ready)  cnt_nxt = '0;
    else if (cnt != LIM)  cnt_nxt = cnt + CW'(1);
  end

  // The flag keys off the next count, so it rises on the edge where the
  // counter saturates. The counter is never cleared by clr, so a writer
  // that is still stalled re-raises the flag one cycle after a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      flag <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (clr)                 flag <= 1'b0;
      else if (cnt_nxt == LIM) flag <= 1'b1;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter.
// Display reads have absolute priority and get a fixed-latency return path.
// The two writers share the leftover slots round-robin.
// Ports: clk, rst_n (async low); blank; disp_req/disp_addr -> disp_rdata/
//        disp_rvalid; wr0_*/wr1_* valid/ready write ports; registered RAM
//        command ram_en/ram_we/ram_addr/ram_wdata, ram_rdata return;
//        starve[1:0] sticky flags with starve_clr.
module vram_arbiter
  import vga_pkg::*;
#(
  parameter int AW            = AW_DEF,
  parameter int DW            = DW_DEF,
  parameter int RAM_LAT       = 1,
  parameter int STARVE_LIMIT  = 1024,
  parameter int WR_BLANK_ONLY = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          blank,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic [DW-1:0] disp_rdata,
  output logic          disp_rvalid,
  input  logic          wr0_valid,
  input  logic [AW-1:0] wr0_addr,
  input  logic [DW-1:0] wr0_data,
  output logic          wr0_ready,
  input  logic          wr1_valid,
  input  logic [AW-1:0] wr1_addr,
  input  logic [DW-1:0] wr1_data,
  output logic          wr1_ready,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [1:0]    starve,
  input  logic          starve_clr
);

  logic [NUM_WR-1:0]         wr_valid, wr_ready;
  logic [NUM_WR-1:0][AW-1:0] wr_addr;
  logic [NUM_WR-1:0][DW-1:0] wr_data;

  assign wr_valid = {wr1_valid, wr0_valid};
  assign wr_addr  = {wr1_addr, wr0_addr};
  assign wr_data  = {wr1_data, wr0_data};

  logic          rr;        // last writer granted: 0 = wr0, 1 = wr1
  logic          wr_ok;
  logic [1:0]    gnt;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [RAM_LAT:0] vld_pipe;  // bit k set: display read issued k+1 cycles ago

  assign wr_ok = (WR_BLANK_ONLY == 0) || blank;

  always_comb begin
    gnt = GNT_NONE;
    if (disp_req)                    gnt = GNT_DISP;
    else if (wr_ok) begin
      if (&wr_valid)                 gnt = rr ? GNT_WR0 : GNT_WR1;
      else if (wr_valid[0])          gnt = GNT_WR0;
      else if (wr_valid[1])          gnt = GNT_WR1;
    end
  end

  assign wr_ready  = {gnt == GNT_WR1, gnt == GNT_WR0};
  assign wr0_ready = wr_ready[0];
  assign wr1_ready = wr_ready[1];

  always_comb begin
    cmd_addr  = '0;
    cmd_wdata = '0;
    if (gnt == GNT_DISP) cmd_addr = disp_addr;
    else if (gnt[1]) begin
      cmd_addr  = wr_addr[gnt[0]];
      cmd_wdata = wr_data[gnt[0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en      <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      rr          <= 1'b1;  // wr0 wins the first tie
      vld_pipe    <= '0;
      disp_rvalid <= 1'b0;
      disp_rdata  <= '0;
    end else begin
      ram_en    <= (gnt != GNT_NONE);
      ram_we    <= gnt[1];
      ram_addr  <= cmd_addr;
      ram_wdata <= cmd_wdata;
      if (gnt[1]) rr <= gnt[0];
      // Stage RAM_LAT lines up with the cycle ram_rdata is valid.
      vld_pipe    <= {vld_pipe[RAM_LAT-1:0], gnt == GNT_DISP};
      disp_rvalid <= vld_pipe[RAM_LAT];
      if (vld_pipe[RAM_LAT]) disp_rdata <= ram_rdata;
    end
  end

  for (genvar i = 0; i < NUM_WR; i++) begin : g_starve
    vram_starve_mon #(
      .STARVE_LIMIT(STARVE_LIMIT)
    ) u_mon (
      .clk   (clk),
      .rst_n (rst_n),
      .valid (wr_valid[i]),
      .ready (wr_ready[i]),
      .clr   (starve_clr),
      .flag  (starve[i])
    );
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port video RAM between three requesters:
  - the VGA scan-out reader, which has a hard real-time deadline;
  - two write requesters: wr0 is the drawing engine, wr1 is the host/debug loader.
- Sits between the VGA timing/pixel pipeline and the frame RAM inside top.
- Display reads always win. Writers share the remaining slots round-robin.
- Sticky starvation flags report writers held off too long; top can route them to Led.

Parameters:
- AW, 15, RAM address width (160x120 frame = 19200 words).
- DW, 8, pixel width (RRRGGGBB).
- RAM_LAT, 1, RAM read latency in cycles from registered command (1..3).
- STARVE_LIMIT, 1024, consecutive stalled cycles before a starve flag sets.
- WR_BLANK_ONLY, 0, 1 = writers granted only while blank=1.

Ports:
- clk in 1 system clock, 50 MHz.
- rst_n in 1 reset, asynchronous, active-low.
- blank in 1 high outside the active video area.
- disp_req in 1 display read request, single-cycle pulse.
- disp_addr in AW display read address.
- disp_rdata out DW returned pixel.
- disp_rvalid out 1 disp_rdata valid, one-cycle pulse.
- wr0_valid in 1 writer 0 request.
- wr0_addr in AW writer 0 address.
- wr0_data in DW writer 0 data.
- wr0_ready out 1 writer 0 accepted this cycle.
- wr1_valid, wr1_addr, wr1_data, wr1_ready: same as wr0, for writer 1.
- ram_en out 1 RAM command strobe.
- ram_we out 1 RAM write enable.
- ram_addr out AW RAM address.
- ram_wdata out DW RAM write data.
- ram_rdata in DW RAM read data.
- starve out 2 sticky starvation flags, bit0 = wr0, bit1 = wr1.
- starve_clr in 1 clears both starve bits.

Behaviour:
- Reset, asynchronous on rst_n low: all outputs 0, pipeline valid stages cleared, rr pointer = wr1 so wr0 wins the first tie, starve counters 0.
- Grant is combinational, one per cycle, in priority order:
  - DISP if disp_req.
  - Otherwise a writer, only if (WR_BLANK_ONLY==0 || blank).
  - Otherwise NONE.
- Writer arbitration:
  - If only one writer is valid, grant it.
  - If both are valid, grant the writer other than the rr pointer.
  - The rr pointer updates only on a writer grant.
- wrX_ready = (grant==WRX). It may depend on wrX_valid. A transfer occurs when valid && ready.
- Requester rule: addr/data stay stable while valid && !ready, and valid must not depend on ready.
- RAM command is registered. A grant in cycle N drives ram_en/ram_we/ram_addr/ram_wdata in cycle N+1.
- ram_en=0 on NONE. ram_we=0 on DISP.
- Read return:
  - ram_rdata is sampled in cycle N+1+RAM_LAT.
  - disp_rdata is registered, with disp_rvalid high in cycle N+2+RAM_LAT. With RAM_LAT=1 this is 3 cycles after disp_req.
  - Tracking uses a RAM_LAT+1 deep valid shift register. Back-to-back reads every cycle are fully pipelined.
- disp_rdata holds its last value when disp_rvalid=0.
- Display is never stalled and has no back-pressure. A disp_req every cycle starves both writers indefinitely; that is legal and is flagged.
- Starvation, per writer:
  - The counter increments while valid && !ready, saturating at STARVE_LIMIT.
  - It resets to 0 on a transfer or when valid=0.
  - When the counter reaches STARVE_LIMIT, starve[x] sets.
- starve_clr clears both bits and wins over a same-cycle set. Counters are not cleared, so a still-saturated counter re-sets the flag the next cycle.
- Mid-operation reset: in-flight reads are dropped, with no disp_rvalid after release. The first grant after release follows the reset rr state.

Decomposition:
- Package vga_pkg holds:
  - AW/DW defaults;
  - grant encoding: GNT_NONE=2'd0, GNT_DISP=2'd1, GNT_WR0=2'd2, GNT_WR1=2'd3;
  - frame geometry constants (160x120), shared with the timing generator.
- Sub-module vram_starve_mon (counter + sticky flag, parameter STARVE_LIMIT), instantiated once per writer.
- Grant logic, command register and read pipeline stay in vram_arbiter.

Test Plan:
- Reset, then a single disp_req with disp_addr=0x0010 and RAM preloaded with 0xA5 there → ram_en=1, ram_we=0 one cycle later; disp_rvalid=1 with disp_rdata=0xA5 exactly 3 cycles after the request; no other rvalid pulses.
- wr0_valid and wr1_valid held together for 6 cycles with no display → grants go wr0,wr1,wr0,wr1,wr0,wr1; each ready is a one-cycle pulse; RAM sees matching addr/data/we=1.
- disp_req and wr0_valid asserted in the same cycle → DISP granted, wr0_ready=0; wr0 transfers the following cycle.
- WR_BLANK_ONLY=1, wr1_valid held with blank=0 for 20 cycles → wr1_ready stays 0; blank rises → wr1_ready=1 the same cycle.
- STARVE_LIMIT=8, disp_req every cycle with wr0_valid=1 → starve=2'b01 after 8 stalled cycles; starve_clr pulse → 0, re-set the next cycle; drop disp_req → starve stays set until cleared.
- rst_n dropped one cycle after two back-to-back disp_req → all outputs 0 immediately; no disp_rvalid after release; the first tied writer grant goes to wr0.
